// File: rtl/irom_responder_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch responder.
//   Zero / Valid / Invalid / RomEnable / RomDisable : common literal values
//   InstW       : instruction and address width
//   irs_state_e : responder FSM states (IRS_IDLE, IRS_FILL)
package irom_responder_pkg;

  localparam int unsigned InstW = 32;

  localparam logic [InstW-1:0] Zero       = '0;
  localparam logic             Valid      = 1'b1;
  localparam logic             Invalid    = 1'b0;
  localparam logic             RomEnable  = 1'b1;
  localparam logic             RomDisable = 1'b0;

  typedef enum logic {
    IRS_IDLE = 1'b0,
    IRS_FILL = 1'b1
  } irs_state_e;

endpackage

// File: rtl/irom_line_buf.sv
// One-line instruction buffer: LINE_WORDS x 32-bit register array.
//   clk   : rising-edge clock
//   we    : write enable (one refill beat)
//   waddr : word index written on we
//   wdata : refill data
//   raddr : word index read combinationally
//   rdata : word at raddr
// Contents are not reset; validity is tracked by the owner.
module irom_line_buf
  import irom_responder_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned OFF_W = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [OFF_W-1:0] waddr,
  input  logic [InstW-1:0] wdata,
  input  logic [OFF_W-1:0] raddr,
  output logic [InstW-1:0] rdata
);

  logic [InstW-1:0] mem_q [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/irom_responder.sv
// Instruction-fetch responder backed by a single LINE_WORDS-word line buffer.
//   clk, rst    : clock; synchronous active-low reset
//   ce, addr    : fetch enable and PC from IF
//   flush       : kill the instruction returned next cycle (IDLE only)
//   invalidate  : drop the buffered line (deferred to fill end while filling)
//   inst, inst_valid, addr_err : registered outputs to ID
//   stall_req   : combinational hold request to IF
//   mem_req, mem_addr, mem_ack, mem_rdata : word-wide refill bus
// A miss refills the whole line, then the held PC hits on the next cycle.
module irom_responder
  import irom_responder_pkg::*;
#(
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [InstW-1:0] addr,
  input  logic             flush,
  input  logic             invalidate,
  output logic [InstW-1:0] inst,
  output logic             inst_valid,
  output logic             addr_err,
  output logic             stall_req,
  output logic             mem_req,
  output logic [InstW-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [InstW-1:0] mem_rdata
);

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned TAG_W = InstW - OFF_W - 2;
  localparam logic [OFF_W-1:0] LastIdx = OFF_W'(LINE_WORDS - 1);

  irs_state_e       state_q, state_d;
  logic             line_valid_q, line_valid_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [OFF_W-1:0] count_q, count_d;
  logic             inv_pend_q, inv_pend_d;
  logic [InstW-1:0] inst_q, inst_d;
  logic             inst_valid_q, inst_valid_d;
  logic             addr_err_q, addr_err_d;
  logic             mem_req_q, mem_req_d;
  logic [InstW-1:0] mem_addr_q, mem_addr_d;

  logic [OFF_W-1:0] offset;
  logic [TAG_W-1:0] tag;
  logic             aligned;
  logic             hit;
  logic             buf_we;
  logic [InstW-1:0] buf_rdata;

  assign offset  = addr[OFF_W+1:2];
  assign tag     = addr[InstW-1:OFF_W+2];
  assign aligned = (addr[1:0] == 2'b00);
  assign hit     = line_valid_q && (tag_q == tag);

  irom_line_buf #(
    .LINE_WORDS(LINE_WORDS)
  ) u_line_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(count_q),
    .wdata(mem_rdata),
    .raddr(offset),
    .rdata(buf_rdata)
  );

  always_comb begin
    state_d      = state_q;
    line_valid_d = line_valid_q;
    tag_d        = tag_q;
    count_d      = count_q;
    inv_pend_d   = inv_pend_q;
    inst_d       = Zero;
    inst_valid_d = Invalid;
    addr_err_d   = 1'b0;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    stall_req    = 1'b0;
    buf_we       = 1'b0;

    case (state_q)
      IRS_IDLE: begin
        // A hit in the same cycle still reads the old contents below.
        if (invalidate) begin
          line_valid_d = Invalid;
        end
        if (ce == RomEnable) begin
          if (!aligned) begin
            addr_err_d = 1'b1;
          end else if (hit) begin
            inst_d       = buf_rdata;
            inst_valid_d = !flush;
          end else begin
            stall_req    = 1'b1;
            state_d      = IRS_FILL;
            tag_d        = tag;
            line_valid_d = Invalid;
            count_d      = '0;
            inv_pend_d   = 1'b0;
            mem_req_d    = 1'b1;
            mem_addr_d   = {tag, {(OFF_W + 2){1'b0}}};
          end
        end
      end

      IRS_FILL: begin
        // flush is ignored here; the redirected PC is looked up after the fill.
        stall_req = 1'b1;
        if (invalidate) begin
          inv_pend_d = 1'b1;
        end
        if (mem_ack && mem_req_q) begin
          buf_we = 1'b1;
          if (count_q == LastIdx) begin
            mem_req_d    = 1'b0;
            state_d      = IRS_IDLE;
            line_valid_d = !(inv_pend_q || invalidate);
            inv_pend_d   = 1'b0;
          end else begin
            count_d    = count_q + OFF_W'(1);
            mem_addr_d = mem_addr_q + InstW'(4);
          end
        end
      end

      default: begin
        state_d = IRS_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IRS_IDLE;
      line_valid_q <= Invalid;
      tag_q        <= '0;
      count_q      <= '0;
      inv_pend_q   <= 1'b0;
      inst_q       <= Zero;
      inst_valid_q <= Invalid;
      addr_err_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= Zero;
    end else begin
      state_q      <= state_d;
      line_valid_q <= line_valid_d;
      tag_q        <= tag_d;
      count_q      <= count_d;
      inv_pend_q   <= inv_pend_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign addr_err   = addr_err_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_irom_responder.sv
// Randomized bench for irom_responder against a line-level reference model.
module tb_irom_responder;

  localparam int unsigned LW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [31:0] addr;
  logic        flush;
  logic        invalidate;
  logic [31:0] inst;
  logic        inst_valid;
  logic        addr_err;
  logic        stall_req;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which line is resident and whether an invalidate hit a fill.
  logic        m_valid;
  logic [31:0] m_base;
  logic        m_pend;

  irom_responder #(
    .LINE_WORDS(LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .addr      (addr),
    .flush     (flush),
    .invalidate(invalidate),
    .inst      (inst),
    .inst_valid(inst_valid),
    .addr_err  (addr_err),
    .stall_req (stall_req),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory contents: 0x100..0x10C hold 0xA0..0xA3.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) + 32'h60;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & ~32'(LW * 4 - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One IDLE-state fetch cycle; reports whether the model predicts a miss.
  task automatic do_fetch(input logic c, input logic [31:0] a, input logic fl,
                          input logic inv, output logic missed);
    logic [31:0] base, ei;
    logic        ev, ee, hit, al;
    ce         = c;
    addr       = a;
    flush      = fl;
    invalidate = inv;
    mem_ack    = ($urandom_range(0, 3) == 0);
    mem_rdata  = $urandom;
    #1;
    base   = line_of(a);
    al     = (a[1:0] == 2'b00);
    hit    = m_valid && (m_base == base);
    missed = c && al && !hit;
    ei = 32'h0;
    ev = 1'b0;
    ee = 1'b0;
    if (c && !al) begin
      ee = 1'b1;
    end else if (c && hit) begin
      ei = mem_word(a);
      ev = !fl;
    end
    if (inv || missed) m_valid = 1'b0;
    check("stall_req", 32'(stall_req), 32'(missed));
    tick();
    check("inst_valid", 32'(inst_valid), 32'(ev));
    check("addr_err", 32'(addr_err), 32'(ee));
    if (!missed) begin
      check("inst", inst, ei);
      check("mem_req_idle", 32'(mem_req), 32'h0);
    end else begin
      check("mem_req_start", 32'(mem_req), 32'h1);
      check("mem_addr_start", mem_addr, base);
    end
  endtask

  // Serve one line refill; gap<0 picks random 0..3 idle cycles before each ack.
  task automatic run_fill(input logic [31:0] base, input int gap, input int inv_beat,
                          input bit rand_inv);
    m_pend = 1'b0;
    for (int b = 0; b < LW; b++) begin
      int g;
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin
        mem_ack    = 1'b0;
        mem_rdata  = $urandom;
        flush      = ($urandom_range(0, 3) == 0);
        invalidate = rand_inv && ($urandom_range(0, 7) == 0);
        if (invalidate) m_pend = 1'b1;
        #1;
        check("fill_stall", 32'(stall_req), 32'h1);
        tick();
        check("fill_req_hold", 32'(mem_req), 32'h1);
        check("fill_addr_hold", mem_addr, base + 32'(4 * b));
        check("fill_valid", 32'(inst_valid), 32'h0);
      end
      mem_ack    = 1'b1;
      mem_rdata  = mem_word(base + 32'(4 * b));
      flush      = ($urandom_range(0, 3) == 0);
      invalidate = (b == inv_beat) ||
                   (rand_inv && (b != LW - 1) && ($urandom_range(0, 7) == 0));
      if (invalidate) m_pend = 1'b1;
      #1;
      check("fill_stall", 32'(stall_req), 32'h1);
      tick();
      check("fill_valid", 32'(inst_valid), 32'h0);
      if (b < LW - 1) begin
        check("fill_req_next", 32'(mem_req), 32'h1);
        check("fill_addr_next", mem_addr, base + 32'(4 * (b + 1)));
      end else begin
        check("fill_req_done", 32'(mem_req), 32'h0);
      end
    end
    mem_ack    = 1'b0;
    invalidate = 1'b0;
    flush      = 1'b0;
    m_valid    = !m_pend;
    m_base     = base;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

  initial begin
    logic        missed;
    logic [31:0] a;
    logic        c, fl, inv;
    int          retries;

    rst        = 1'b0;
    ce         = 1'b0;
    addr       = 32'h0;
    flush      = 1'b0;
    invalidate = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    m_valid    = 1'b0;
    m_base     = 32'h0;
    m_pend     = 1'b0;

    tick();
    tick();
    check("rst_inst", inst, 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_addr_err", 32'(addr_err), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_stall", 32'(stall_req), 32'h0);
    rst = 1'b1;

    // Cold miss with an immediate-ack bus, then sequential hits.
    do_fetch(1'b1, 32'h100, 1'b0, 1'b0, missed);
    check("cold_miss", 32'(missed), 32'h1);
    run_fill(32'h100, 0, -1, 1'b0);
    do_fetch(1'b1, 32'h100, 1'b0, 1'b0, missed);
    check("first_word", inst, 32'hA0);
    do_fetch(1'b1, 32'h104, 1'b0, 1'b0, missed);
    do_fetch(1'b1, 32'h108, 1'b0, 1'b0, missed);
    do_fetch(1'b1, 32'h10C, 1'b0, 1'b0, missed);
    check("last_word", inst, 32'hA3);

    // Slow bus with fixed 3-cycle gaps.
    do_fetch(1'b1, 32'h408, 1'b0, 1'b0, missed);
    run_fill(32'h400, 3, -1, 1'b0);
    do_fetch(1'b1, 32'h408, 1'b0, 1'b0, missed);

    // Misaligned fetch, then an aligned one clears addr_err; ce low idles.
    do_fetch(1'b1, 32'h402, 1'b0, 1'b0, missed);
    do_fetch(1'b1, 32'h400, 1'b0, 1'b0, missed);
    do_fetch(1'b0, 32'h404, 1'b0, 1'b0, missed);

    // Invalidate on the second beat: the line refetches after the fill.
    do_fetch(1'b1, 32'h200, 1'b0, 1'b0, missed);
    run_fill(32'h200, 1, 1, 1'b0);
    do_fetch(1'b1, 32'h200, 1'b0, 1'b0, missed);
    check("inv_refetch", 32'(missed), 32'h1);
    run_fill(32'h200, 0, -1, 1'b0);
    do_fetch(1'b1, 32'h200, 1'b0, 1'b0, missed);
    do_fetch(1'b1, 32'h204, 1'b1, 1'b0, missed);

    // Reset after the first beat of a fill.
    do_fetch(1'b1, 32'h300, 1'b0, 1'b0, missed);
    mem_ack   = 1'b1;
    mem_rdata = mem_word(32'h300);
    tick();
    check("mid_req", 32'(mem_req), 32'h1);
    check("mid_addr", mem_addr, 32'h304);
    rst       = 1'b0;
    mem_rdata = mem_word(32'h304);
    tick();
    check("midrst_req", 32'(mem_req), 32'h0);
    check("midrst_valid", 32'(inst_valid), 32'h0);
    check("midrst_addr", mem_addr, 32'h0);
    rst     = 1'b1;
    mem_ack = 1'b0;
    m_valid = 1'b0;
    do_fetch(1'b1, 32'h300, 1'b0, 1'b0, missed);
    check("midrst_miss", 32'(missed), 32'h1);
    run_fill(32'h300, -1, -1, 1'b0);

    // Randomized traffic over a few hot lines plus random ones.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 32'h100;
        1:       a = 32'h200;
        2:       a = 32'h300;
        3:       a = 32'hFFFF_FFF0;
        default: a = $urandom & ~32'hF;
      endcase
      a = a | 32'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      c   = ($urandom_range(0, 7) != 0);
      fl  = ($urandom_range(0, 7) == 0);
      inv = ($urandom_range(0, 9) == 0);
      do_fetch(c, a, fl, inv, missed);
      if (missed) begin
        run_fill(line_of(a), -1, -1, 1'b1);
        retries = 0;
        while (missed && retries < 4) begin
          do_fetch(1'b1, a, 1'b0, 1'b0, missed);
          if (missed) run_fill(line_of(a), -1, -1, 1'b0);
          retries++;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irom_responder.md
Name: irom_responder

Overview:
- Responder on the instruction-fetch side of the fetch interface: it accepts `ce`/`addr` from the fetch stage and returns the instruction word one cycle later.
- Backed by a one-line, LINE_WORDS-word instruction buffer, refilled from a slower word-wide memory bus through a req/ack handshake.
- On a miss it raises `stall_req` so the fetch stage holds its PC until the line is resident.
- Sits between the IF stage, the ID-stage instruction register and the external instruction memory.

Parameters:
- LINE_WORDS, 4, words per buffer line; power of two, at least 2.
- OFF_W, log2(LINE_WORDS) = 2, word-offset field width; derived, not overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset; rst==0 at a posedge resets the block.
- ce  input  1  fetch enable from the IF stage.
- addr  input  32  fetch PC from the IF stage.
- flush  input  1  kill the instruction being returned (jump/exception redirect).
- invalidate  input  1  discard buffer contents (self-modifying code / fence).
- inst  output  32  registered instruction word to ID.
- inst_valid  output  1  inst holds a live instruction this cycle.
- addr_err  output  1  registered pulse: fetch address not word aligned.
- stall_req  output  1  combinational request to the fetch stage to hold the PC.
- mem_req  output  1  backing-bus read request; held until mem_ack.
- mem_addr  output  32  backing-bus word address; bits [1:0] always 0.
- mem_ack  input  1  backing-bus data-valid strobe.
- mem_rdata  input  32  backing-bus read data.

Behaviour:
- Address fields:
  - offset = addr[OFF_W+1:2].
  - tag = addr[31:OFF_W+2].
  - line base = {tag, OFF_W+2 zero bits}.
- Reset (rst==0): state IDLE, line_valid=0, tag=0, fill count=0, inv_pend=0; inst=0, inst_valid=0, addr_err=0, mem_req=0, mem_addr=0.
- Reset wins over every other input, including mid-FILL.
  - mem_req drops at that edge.
  - The outstanding bus beat is abandoned.
- ce==0: at the next edge inst<=0, inst_valid<=0, addr_err<=0; no lookup; stall_req=0.
- States: IDLE and FILL.
- IDLE, ce=1, addr[1:0]!=0:
  - Next edge: addr_err<=1, inst<=0, inst_valid<=0.
  - No fill; stall_req=0.
- IDLE, ce=1, aligned hit (line_valid and tag match):
  - Next edge: inst<=buf[offset], inst_valid<=!flush.
  - Latency 1 cycle; stall_req=0; back-to-back hits every cycle.
- IDLE, ce=1, aligned miss:
  - stall_req=1 combinationally in the same cycle.
  - Next edge: state<=FILL, tag latched, line_valid<=0, count<=0, mem_req<=1, mem_addr<=line base, inst_valid<=0.
- FILL:
  - stall_req=1 and inst_valid=0 for every cycle in this state.
  - On mem_ack: buf[count]<=mem_rdata.
  - If count < LINE_WORDS-1: count<=count+1, mem_addr<=mem_addr+4, mem_req stays 1 (back-to-back beats allowed).
  - If count == LINE_WORDS-1: mem_req<=0, state<=IDLE, line_valid<=!inv_pend, inv_pend<=0.
  - With no mem_ack, all state holds; there is no timeout.
- After a fill: the held PC hits in IDLE on the following cycle. Miss penalty = LINE_WORDS ack cycles + 2.
- flush:
  - In IDLE it forces inst_valid<=0 at the next edge.
  - In FILL it has no effect; a bus transaction is never aborted. The redirected PC is looked up after the fill.
- invalidate:
  - In IDLE: line_valid<=0 at the next edge. If it coincides with a hit, that hit's data is still returned.
  - In FILL: sets inv_pend, so the completing line stays invalid.
- mem_ack while mem_req==0: ignored.
- Arithmetic: mem_addr increments modulo 2^32. A line never crosses its base, so no wrap occurs inside a line.

Decomposition:
- Shared package (alongside the existing define file):
  - Zero, Valid/Invalid, RomEnable/RomDisable constants.
  - FSM state encodings IRS_IDLE/IRS_FILL.
  - Instruction/address width constant 32.
- One natural sub-module: irom_line_buf, the LINE_WORDS x 32 register array with one write port (count, mem_rdata, write-enable) and one combinational read port (offset).
- The FSM, tag compare and bus handshake stay in the top.

Test Plan:
- Cold miss, addr=0x0000_0100, ce=1:
  - stall_req=1 in the same cycle.
  - mem_req with mem_addr 0x100, 0x104, 0x108, 0x10C.
  - Memory acks immediately with data 0xA0..0xA3.
  - Two cycles after the last ack: inst=0xA0, inst_valid=1, stall_req=0.
- Sequential hits at 0x104, 0x108, 0x10C on consecutive cycles: inst=0xA1, 0xA2, 0xA3 each one cycle later; mem_req stays 0.
- Slow bus, 3-cycle ack gaps per beat: mem_addr and mem_req held steady between acks; a mem_ack pulse with mem_req=0 changes nothing.
- Misaligned addr=0x102: next cycle addr_err=1, inst=0, inst_valid=0, no mem_req; an aligned fetch the following cycle clears addr_err.
- Invalidate: assert during the second beat of a fill to 0x200. The fill completes, then the 0x200 lookup misses again and refetches. Flush on a hit yields inst_valid=0.
- Reset mid-FILL: rst=0 after beat 1 gives mem_req=0, inst_valid=0, line_valid=0 next edge; the next fetch of the same line misses.
